debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_sync.sv | 110 +++++++++++
 tb/tb_debounce_sync.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Two-channel push-button conditioner: per-channel 2-flop synchronizer followed by a
// counting debounce FSM with a registered level and a one-cycle rising-edge pulse.
module debounce_sync #(
  parameter int unsigned N_CYC = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise
);

  typedef enum logic [1:0] {
    StLow,
    StWaitHigh,
    StHigh,
    StWaitLow
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(N_CYC - 1);

  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] rise;

  assign raw = {b_raw, a_raw};

  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic             s1_q;
    logic             s2_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= raw[i];
        s2_q <= s1_q;
      end
    end

    // Any opposite sample while waiting aborts; re-entry restarts the count at zero.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StLow;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        unique case (state_q)
          StLow: begin
            if (s2_q) begin
              state_q <= StWaitHigh;
              cnt_q   <= '0;
            end
          end
          StWaitHigh: begin
            if (!s2_q) begin
              state_q <= StLow;
            end else if (cnt_q == CntLast) begin
              state_q <= StHigh;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StHigh: begin
            if (!s2_q) begin
              state_q <= StWaitLow;
              cnt_q   <= '0;
            end
          end
          StWaitLow: begin
            if (s2_q) begin
              state_q <= StHigh;
            end else if (cnt_q == CntLast) begin
              state_q <= StLow;
              level_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StLow;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign level[i] = level_q;
    assign rise[i]  = rise_q;
  end

  assign a      = level[0];
  assign b      = level[1];
  assign a_rise = rise[0];
  assign b_rise = rise[1];

endmodule

// File: tb/tb_debounce_sync.sv
// Randomized and directed bench for debounce_sync (N_CYC=4 and N_CYC=1 instances),
// checked against a run-length reference model of the accept rule.
module tb_debounce_sync;

  localparam int unsigned N0 = 4;
  localparam int unsigned N1 = 1;

  logic clk = 1'b0;
  logic reset;
  logic a_raw;
  logic b_raw;
  logic a0, b0, ar0, br0;
  logic a1, b1, ar1, br1;

  always #5 clk = ~clk;

  debounce_sync #(.N_CYC(N0), .CNT_W(3)) u_dut0 (
    .clk    (clk),
    .reset  (reset),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a      (a0),
    .b      (b0),
    .a_rise (ar0),
    .b_rise (br0)
  );

  debounce_sync #(.N_CYC(N1), .CNT_W(1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .a      (a1),
    .b      (b1),
    .a_rise (ar1),
    .b_rise (br1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a level flips once the synchronized input has disagreed with it for
  // N+1 consecutive sampling edges; the raw input reaches the compare point 2 edges late.
  int unsigned ncyc [2];
  logic m_s1   [2][2];
  logic m_s2   [2][2];
  logic m_lvl  [2][2];
  logic m_rise [2][2];
  int   m_run  [2][2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[d][c]   = 1'b0;
        m_s2[d][c]   = 1'b0;
        m_lvl[d][c]  = 1'b0;
        m_rise[d][c] = 1'b0;
        m_run[d][c]  = 0;
      end
    end
  endtask

  task automatic model_edge(input logic ra, input logic rb);
    logic seen;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        seen = m_s2[d][c];
        m_rise[d][c] = 1'b0;
        if (seen != m_lvl[d][c]) begin
          m_run[d][c]++;
          if (m_run[d][c] == int'(ncyc[d]) + 1) begin
            m_lvl[d][c]  = seen;
            m_rise[d][c] = seen;
            m_run[d][c]  = 0;
          end
        end else begin
          m_run[d][c] = 0;
        end
        m_s2[d][c] = m_s1[d][c];
        m_s1[d][c] = (c == 0) ? ra : rb;
      end
    end
  endtask

  task automatic compare_model();
    check_eq("n4_a",      a0,  m_lvl[0][0]);
    check_eq("n4_b",      b0,  m_lvl[0][1]);
    check_eq("n4_a_rise", ar0, m_rise[0][0]);
    check_eq("n4_b_rise", br0, m_rise[0][1]);
    check_eq("n1_a",      a1,  m_lvl[1][0]);
    check_eq("n1_b",      b1,  m_lvl[1][1]);
    check_eq("n1_a_rise", ar1, m_rise[1][0]);
    check_eq("n1_b_rise", br1, m_rise[1][1]);
  endtask

  task automatic cycle(input logic ra, input logic rb, input logic rst);
    @(negedge clk);
    a_raw = ra;
    b_raw = rb;
    reset = rst;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(ra, rb);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  int   rises;
  int   hold_a, hold_b;
  logic ra, rb, rst;

  initial begin
    ncyc[0] = N0;
    ncyc[1] = N1;
    reset = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b0;
    model_reset();

    // Held in reset: everything low.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 1'b1);
      check_eq("rst_outs", {a0, b0, ar0, br0, a1, b1, ar1, br1}, 8'h00);
    end

    // Clean rise on A: level after edge 6 (N=4) / edge 3 (N=1), single pulse.
    rises = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("rise_a_lvl", a0, (k >= 6));
      check_eq("rise_a_pls", ar0, (k == 6));
      check_eq("rise_b_idle", {b0, br0}, 2'b00);
      check_eq("rise_a_n1", a1, (k >= 3));
      rises += ar0;
    end
    check_eq("rise_a_count", rises, 1);

    // Clean fall on A: no pulse.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      check_eq("fall_a_lvl", a0, (k < 6));
      check_eq("fall_a_nopls", ar0, 1'b0);
    end

    // Bounce: 3 high samples are rejected.
    for (int k = 0; k < 12; k++) begin
      cycle((k < 3), 1'b0, 1'b0);
      check_eq("bounce_a", {a0, ar0}, 2'b00);
    end

    // Go high, then a 2-cycle low glitch must not drop the level.
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cycle((k < 2) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      check_eq("glitch_a_hold", a0, 1'b1);
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0);

    // Simultaneous rise on both channels.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      check_eq("both_lvl", {a0, b0}, (k >= 6) ? 2'b11 : 2'b00);
      check_eq("both_pls", {ar0, br0}, (k == 6) ? 2'b11 : 2'b00);
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0);

    // Reset mid-debounce with raw held high: full re-debounce, one pulse.
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("midrst_clear", {a0, ar0}, 2'b00);
    rises = 0;
    for (int j = 0; j < 10; j++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("midrst_lvl", a0, (j >= 6));
      rises += ar0;
    end
    check_eq("midrst_count", rises, 1);

    // Random run-length stimulus with occasional resets.
    ra = 1'b0;
    rb = 1'b0;
    hold_a = 0;
    hold_b = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_a == 0) begin
        ra = ~ra;
        hold_a = $urandom_range(1, 8);
      end
      if (hold_b == 0) begin
        rb = ~rb;
        hold_b = $urandom_range(1, 8);
      end
      hold_a--;
      hold_b--;
      rst = ($urandom_range(0, 299) == 0);
      cycle(ra, rb, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
